// File: rtl/otter_pipe_ctrl.sv
// OTTER 5-stage pipeline controller: owns the DEC/EXE/MEM/WB instruction registers,
// resolves hazards and redirects, and sequences interrupt entry.
module otter_pipe_ctrl #(
  parameter bit          FORWARDING = 1'b1,
  parameter bit          INT_EN     = 1'b1,
  parameter logic [31:0] NOP_IR     = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_ir,
  input  logic        if_valid,
  input  logic        br_eq,
  input  logic        br_lt,
  input  logic        br_ltu,
  input  logic        mem_ready,
  input  logic        int_req,
  input  logic        mie,
  output logic [31:0] dec_ir,
  output logic [31:0] exe_ir,
  output logic [31:0] mem_ir,
  output logic [31:0] wb_ir,
  output logic        pc_write,
  output logic [2:0]  pc_source,
  output logic        alu_srca,
  output logic [1:0]  alu_srcb,
  output logic [3:0]  alu_func,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_read2,
  output logic        mem_write2,
  output logic        mem_sign,
  output logic [1:0]  mem_size,
  output logic        reg_wr_en,
  output logic        csr_write,
  output logic [1:0]  rf_wr_sel,
  output logic        int_taken
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {RUN, DRAIN, JUMP} int_state_t;

  int_state_t  state, state_next;
  logic [31:0] dec_d, exe_d, mem_d, wb_d;
  logic        redirect, br_taken, raw_stall;
  logic [2:0]  redirect_src;

  function automatic logic writes_rd(input logic [31:0] ir);
    logic op_ok;
    case (ir[6:0])
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD, OP_OP, OP_IMM: op_ok = 1'b1;
      OP_SYSTEM: op_ok = (ir[14:12] != 3'b000);
      default:   op_ok = 1'b0;
    endcase
    return op_ok && (ir[11:7] != 5'd0);
  endfunction

  // CSR immediate forms (f3[2]=1) carry a zimm in the rs1 field, not a register
  function automatic logic uses_rs1(input logic [31:0] ir);
    logic used;
    case (ir[6:0])
      OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM, OP_OP: used = 1'b1;
      OP_SYSTEM: used = (ir[14:12] != 3'b000) && !ir[14];
      default:   used = 1'b0;
    endcase
    return used;
  endfunction

  function automatic logic uses_rs2(input logic [31:0] ir);
    return (ir[6:0] == OP_BRANCH) || (ir[6:0] == OP_STORE) || (ir[6:0] == OP_OP);
  endfunction

  function automatic logic depends_on(input logic [31:0] cons, input logic [31:0] prod);
    return writes_rd(prod) &&
           ((uses_rs1(cons) && (cons[19:15] == prod[11:7])) ||
            (uses_rs2(cons) && (cons[24:20] == prod[11:7])));
  endfunction

  function automatic logic [1:0] fwd_src(input logic [4:0] rs, input logic used,
                                         input logic [31:0] mir, input logic [31:0] wir);
    logic [1:0] src;
    src = 2'd0;
    if (FORWARDING && used) begin
      if (writes_rd(mir) && (mir[6:0] != OP_LOAD) && (mir[11:7] == rs))
        src = 2'd1;
      else if (writes_rd(wir) && (wir[11:7] == rs))
        src = 2'd2;
    end
    return src;
  endfunction

  always_comb begin
    br_taken = 1'b0;
    case (exe_ir[14:12])
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    redirect     = 1'b0;
    redirect_src = 3'd0;
    case (exe_ir[6:0])
      OP_JAL:    begin redirect = 1'b1;     redirect_src = 3'd3; end
      OP_JALR:   begin redirect = 1'b1;     redirect_src = 3'd1; end
      OP_BRANCH: begin redirect = br_taken; redirect_src = 3'd2; end
      OP_SYSTEM: begin
        redirect     = (exe_ir[14:12] == 3'b000);
        redirect_src = 3'd5;
      end
      default: ;
    endcase
  end

  // Without forwarding, the regfile write-through only covers the WB stage
  always_comb begin
    if (FORWARDING)
      raw_stall = (exe_ir[6:0] == OP_LOAD) && depends_on(dec_ir, exe_ir);
    else
      raw_stall = depends_on(dec_ir, exe_ir) || depends_on(dec_ir, mem_ir);
  end

  assign fwd_a = fwd_src(exe_ir[19:15], uses_rs1(exe_ir), mem_ir, wb_ir);
  assign fwd_b = fwd_src(exe_ir[24:20], uses_rs2(exe_ir), mem_ir, wb_ir);

  // Stage steering and interrupt FSM; a memory wait overrides everything else
  always_comb begin
    state_next = state;
    pc_write   = 1'b1;
    pc_source  = 3'd0;
    int_taken  = 1'b0;
    dec_d      = if_valid ? if_ir : NOP_IR;
    exe_d      = dec_ir;
    mem_d      = exe_ir;
    wb_d       = mem_ir;
    if (!mem_ready) begin
      dec_d    = dec_ir;
      exe_d    = exe_ir;
      mem_d    = mem_ir;
      wb_d     = NOP_IR;
      pc_write = 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (redirect) begin
            pc_source = redirect_src;
            dec_d     = NOP_IR;
            exe_d     = NOP_IR;
          end else if (raw_stall) begin
            pc_write = 1'b0;
            dec_d    = dec_ir;
            exe_d    = NOP_IR;
          end else if (INT_EN && int_req && mie) begin
            state_next = DRAIN;
          end
        end
        DRAIN: begin
          pc_write = 1'b0;
          dec_d    = dec_ir;
          exe_d    = NOP_IR;
          if ((exe_ir == NOP_IR) && (mem_ir == NOP_IR))
            state_next = JUMP;
        end
        JUMP: begin
          int_taken  = 1'b1;
          pc_source  = 3'd4;
          dec_d      = NOP_IR;
          exe_d      = NOP_IR;
          state_next = RUN;
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      dec_ir <= NOP_IR;
      exe_ir <= NOP_IR;
      mem_ir <= NOP_IR;
      wb_ir  <= NOP_IR;
    end else begin
      state  <= state_next;
      dec_ir <= dec_d;
      exe_ir <= exe_d;
      mem_ir <= mem_d;
      wb_ir  <= wb_d;
    end
  end

  assign alu_srca = (dec_ir[6:0] == OP_LUI) || (dec_ir[6:0] == OP_AUIPC);

  always_comb begin
    case (dec_ir[6:0])
      OP_IMM, OP_LOAD: alu_srcb = 2'd1;
      OP_STORE:        alu_srcb = 2'd2;
      OP_AUIPC:        alu_srcb = 2'd3;
      default:         alu_srcb = 2'd0;
    endcase
  end

  // Only shift-right-immediate uses bit 30 as a function select among OP_IMM ops
  always_comb begin
    case (exe_ir[6:0])
      OP_OP:             alu_func = {exe_ir[30], exe_ir[14:12]};
      OP_IMM:            alu_func = {exe_ir[30] & (exe_ir[14:12] == 3'b101), exe_ir[14:12]};
      OP_LUI, OP_SYSTEM: alu_func = 4'd9;
      default:           alu_func = 4'd0;
    endcase
  end

  assign mem_read2  = (mem_ir[6:0] == OP_LOAD);
  assign mem_write2 = (mem_ir[6:0] == OP_STORE);
  assign mem_sign   = !mem_ir[14];
  assign mem_size   = mem_ir[13:12];

  assign reg_wr_en = writes_rd(wb_ir);
  assign csr_write = (wb_ir[6:0] == OP_SYSTEM) && (wb_ir[14:12] != 3'b000);

  always_comb begin
    case (wb_ir[6:0])
      OP_LOAD:                           rf_wr_sel = 2'd2;
      OP_SYSTEM:                         rf_wr_sel = 2'd1;
      OP_LUI, OP_AUIPC, OP_OP, OP_IMM:   rf_wr_sel = 2'd3;
      default:                           rf_wr_sel = 2'd0;
    endcase
  end

endmodule
